// File: rtl/xorshift_seed_finder_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : xorshift_seed_finder_pkg                                     |
// | Purpose : Shared constants for the xorshift32 seed finder: the eight    |
// |           accepted 7-segment patterns {g,f,e,d,c,b,a}, the FSM state   |
// |           encoding, the xorshift shift amounts and a one-step helper.  |
// | Ports   : none (package)                                               |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package xorshift_seed_finder_pkg;

   // Segment patterns for digits 0..7, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] c_seg_0 = 7'b0111111;
   localparam logic [6:0] c_seg_1 = 7'b0000110;
   localparam logic [6:0] c_seg_2 = 7'b1011011;
   localparam logic [6:0] c_seg_3 = 7'b1001111;
   localparam logic [6:0] c_seg_4 = 7'b1100110;
   localparam logic [6:0] c_seg_5 = 7'b1101101;
   localparam logic [6:0] c_seg_6 = 7'b1111100;
   localparam logic [6:0] c_seg_7 = 7'b0000111;

   // xorshift32 shift amounts, applied in this order: <<, >>, <<
   localparam int c_shift_a = 13;
   localparam int c_shift_b = 17;
   localparam int c_shift_c = 5;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_COLLECT   = 3'd1,
      ST_SEARCH    = 3'd2,
      ST_DONE_OK   = 3'd3,
      ST_DONE_FAIL = 3'd4
   } state_t;

   // One xorshift32 step with 32-bit truncating shifts
   function automatic logic [31:0] xs_step(input logic [31:0] s);
      logic [31:0] t;
      t = s ^ (s << c_shift_a);
      t = t ^ (t >> c_shift_b);
      t = t ^ (t << c_shift_c);
      return t;
   endfunction

endpackage
`default_nettype wire

// File: rtl/xorshift_seed_finder_seg7_decode.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : xorshift_seed_finder_seg7_decode                             |
// | Purpose : Combinational 7-segment to 3-bit digit decoder. Only the     |
// |           eight generator patterns (digits 0..7) are accepted.         |
// | Ports   : i_seg   [6:0] in  segment pattern {g,f,e,d,c,b,a}            |
// |           o_valid       out pattern is one of the eight digits         |
// |           o_digit [2:0] out decoded digit (0 when not valid)           |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module xorshift_seed_finder_seg7_decode
   import xorshift_seed_finder_pkg::*;
(
   input  logic [6:0] i_seg,
   output logic       o_valid,
   output logic [2:0] o_digit
);

   always_comb begin
      o_valid = 1'b1;
      o_digit = 3'd0;
      case (i_seg)
         c_seg_0: o_digit = 3'd0;
         c_seg_1: o_digit = 3'd1;
         c_seg_2: o_digit = 3'd2;
         c_seg_3: o_digit = 3'd3;
         c_seg_4: o_digit = 3'd4;
         c_seg_5: o_digit = 3'd5;
         c_seg_6: o_digit = 3'd6;
         c_seg_7: o_digit = 3'd7;
         default: begin
            o_valid = 1'b0;
            o_digit = 3'd0;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/xorshift_seed_finder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : xorshift_seed_finder                                         |
// | Purpose : Watches the 7-segment output of an xorshift32 digit          |
// |           generator, buffers N_OBS decoded digits, then brute-forces   |
// |           every seed (one xorshift step per cycle, ascending) and      |
// |           reports the lowest seed consistent with the observations.    |
// | Ports   : clk            in  clock                                     |
// |           reset          in  synchronous, active-high                  |
// |           seg_valid      in  1-cycle strobe, seg_in holds a new digit  |
// |           seg_in   [6:0] in  segment pattern {g,f,e,d,c,b,a}           |
// |           busy           out collecting (>=1 sample) or searching      |
// |           found          out search succeeded (DONE_OK)                |
// |           fail           out no seed matched (DONE_FAIL)               |
// |           bad_seg        out 1-cycle pulse on an undecodable strobe    |
// |           seed_out       out recovered seed while found, else 0        |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module xorshift_seed_finder
   import xorshift_seed_finder_pkg::*;
#(
   parameter int N_OBS  = 4,
   parameter int SEED_W = 6
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              seg_valid,
   input  logic [6:0]        seg_in,
   output logic              busy,
   output logic              found,
   output logic              fail,
   output logic              bad_seg,
   output logic [SEED_W-1:0] seed_out
);

   localparam int c_cnt_w = $clog2(N_OBS + 1);
   localparam int c_k_w   = $clog2(N_OBS);
   // cand carries one extra bit so the last-seed test is an exact compare
   localparam logic [SEED_W:0] c_cand_last = {1'b0, {SEED_W{1'b1}}};

   state_t              r_state;
   state_t              w_state_next;

   logic [c_cnt_w-1:0]  r_cnt;
   logic [2:0]          r_obs [N_OBS];
   logic [SEED_W:0]     r_cand;
   logic [c_k_w-1:0]    r_k;
   logic [31:0]         r_s;
   logic                r_bad_seg;

   logic                w_dec_valid;
   logic [2:0]          w_dec_digit;
   logic [31:0]         w_s_next;
   logic [2:0]          w_obs_k;
   logic [SEED_W:0]     w_cand_inc;

   // FSM-issued datapath commands
   logic                w_store_first;
   logic                w_store_next;
   logic                w_start;
   logic                w_advance;
   logic                w_next_cand;
   logic                w_bad;

   xorshift_seed_finder_seg7_decode u_dec (
      .i_seg   (seg_in),
      .o_valid (w_dec_valid),
      .o_digit (w_dec_digit)
   );

   assign w_s_next   = xs_step(r_s);
   assign w_cand_inc = r_cand + {{SEED_W{1'b0}}, 1'b1};

   // Observation selected by the search index
   always_comb begin
      w_obs_k = 3'd0;
      for (int i = 0; i < N_OBS; i++) begin
         if (r_k == c_k_w'(i)) begin
            w_obs_k = r_obs[i];
         end
      end
   end

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------------------------------------------------------------
   // Next state, datapath commands and status outputs
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_next  = r_state;
      w_store_first = 1'b0;
      w_store_next  = 1'b0;
      w_start       = 1'b0;
      w_advance     = 1'b0;
      w_next_cand   = 1'b0;
      w_bad         = 1'b0;
      busy          = 1'b0;
      found         = 1'b0;
      fail          = 1'b0;
      seed_out      = '0;

      case (r_state)
         ST_IDLE, ST_DONE_OK, ST_DONE_FAIL: begin
            // N_OBS >= 2, so a first sample can never complete a set
            if (seg_valid) begin
               if (w_dec_valid) begin
                  w_store_first = 1'b1;
                  w_state_next  = ST_COLLECT;
               end else begin
                  w_bad = 1'b1;
               end
            end
         end

         ST_COLLECT: begin
            if (seg_valid) begin
               if (w_dec_valid) begin
                  w_store_next = 1'b1;
                  if (r_cnt == c_cnt_w'(N_OBS - 1)) begin
                     w_start      = 1'b1;
                     w_state_next = ST_SEARCH;
                  end
               end else begin
                  w_bad = 1'b1;
               end
            end
         end

         ST_SEARCH: begin
            // Strobes are deliberately ignored here, including bad patterns
            if (w_s_next[2:0] == w_obs_k) begin
               if (r_k == c_k_w'(N_OBS - 1)) begin
                  w_state_next = ST_DONE_OK;
               end else begin
                  w_advance = 1'b1;
               end
            end else if (r_cand == c_cand_last) begin
               w_state_next = ST_DONE_FAIL;
            end else begin
               w_next_cand = 1'b1;
            end
         end

         default: begin
            w_state_next = ST_IDLE;
         end
      endcase

      busy  = (r_state == ST_COLLECT) || (r_state == ST_SEARCH);
      found = (r_state == ST_DONE_OK);
      fail  = (r_state == ST_DONE_FAIL);
      // cand is frozen in DONE_OK, so it doubles as the result register
      if (r_state == ST_DONE_OK) begin
         seed_out = r_cand[SEED_W-1:0];
      end
   end

   assign bad_seg = r_bad_seg;

   // ---------------------------------------------------------------------
   // Datapath: observation buffer, counters, xorshift state
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt     <= '0;
         r_cand    <= '0;
         r_k       <= '0;
         r_s       <= '0;
         r_bad_seg <= 1'b0;
         for (int i = 0; i < N_OBS; i++) begin
            r_obs[i] <= 3'd0;
         end
      end else begin
         r_bad_seg <= w_bad;

         if (w_store_first) begin
            r_obs[0] <= w_dec_digit;
            r_cnt    <= c_cnt_w'(1);
         end

         if (w_store_next) begin
            for (int i = 0; i < N_OBS; i++) begin
               if (r_cnt == c_cnt_w'(i)) begin
                  r_obs[i] <= w_dec_digit;
               end
            end
            r_cnt <= r_cnt + c_cnt_w'(1);
         end

         if (w_start) begin
            r_cand <= '0;
            r_k    <= '0;
            r_s    <= '0;
         end

         if (w_advance) begin
            r_s <= w_s_next;
            r_k <= r_k + c_k_w'(1);
         end

         if (w_next_cand) begin
            r_cand <= w_cand_inc;
            r_k    <= '0;
            r_s    <= {{(32 - SEED_W - 1){1'b0}}, w_cand_inc};
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_xorshift_seed_finder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_xorshift_seed_finder                                      |
// | Purpose : Self-checking bench for xorshift_seed_finder: table vectors, |
// |           every seed, random digit sets, bad patterns, reset abort     |
// |           and strobes during the search.                               |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_xorshift_seed_finder;

   localparam int NOBS  = 4;
   localparam int SW    = 6;
   localparam int NSEED = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic          seg_valid;
   logic [6:0]    seg_in;
   logic          busy;
   logic          found;
   logic          fail;
   logic          bad_seg;
   logic [SW-1:0] seed_out;

   int checks = 0;
   int errors = 0;

   logic [6:0] seg_pat [8];
   int         dig [NSEED][NOBS];

   typedef struct {
      logic [11:0] d;
      bit          exp_found;
      int          exp_seed;
   } vec_t;
   vec_t vecs [3];

   always #5 clk = ~clk;

   xorshift_seed_finder #(.N_OBS(NOBS), .SEED_W(SW)) dut (
      .clk       (clk),
      .reset     (reset),
      .seg_valid (seg_valid),
      .seg_in    (seg_in),
      .busy      (busy),
      .found     (found),
      .fail      (fail),
      .bad_seg   (bad_seg),
      .seed_out  (seed_out)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   // Generator digits straight from the xorshift32 definition
   function automatic int model_digit(input int seed, input int k);
      logic [31:0] s;
      s = 32'(seed);
      for (int i = 0; i <= k; i++) begin
         s = s ^ (s << 13);
         s = s ^ (s >> 17);
         s = s ^ (s << 5);
      end
      return int'(s[2:0]);
   endfunction

   // Lowest consistent seed; cyc = steps tried until the first mismatch
   // of each rejected seed plus N_OBS for the accepted one
   task automatic model_search(input logic [11:0] d, output bit ok,
                               output int seed, output int cyc);
      ok = 1'b0; seed = 0; cyc = 0;
      for (int c = 0; c < NSEED && !ok; c++) begin
         bit m;
         m = 1'b1;
         for (int k = 0; k < NOBS && m; k++) begin
            cyc++;
            if (dig[c][k] != int'(d[3*k +: 3])) m = 1'b0;
         end
         if (m) begin
            ok = 1'b1;
            seed = c;
         end
      end
   endtask

   function automatic logic [11:0] pack_seed(input int s);
      logic [11:0] d;
      for (int k = 0; k < NOBS; k++) d[3*k +: 3] = 3'(dig[s][k]);
      return d;
   endfunction

   // Called at a negedge; returns at the negedge after the sampling edge
   task automatic send_sample(input logic [6:0] p);
      seg_valid = 1'b1;
      seg_in    = p;
      @(negedge clk);
      seg_valid = 1'b0;
      seg_in    = 7'd0;
   endtask

   task automatic wait_result(input string name, input bit exp_ok, input int exp_seed,
                              input int exp_cyc, input bit noise);
      int n;
      logic [2:0] r;
      n = 0;
      check({name, "_busy"}, int'(busy), 1);
      while (found !== 1'b1 && fail !== 1'b1 && n < 400) begin
         if (noise && n < 3) begin
            r = 3'($urandom_range(7, 0));
            seg_valid = 1'b1;
            seg_in    = seg_pat[r];
         end
         @(negedge clk);
         seg_valid = 1'b0;
         seg_in    = 7'd0;
         n++;
      end
      check({name, "_latency"}, n, exp_cyc);
      check({name, "_found"}, int'(found), int'(exp_ok));
      check({name, "_fail"}, int'(fail), int'(!exp_ok));
      check({name, "_seed"}, int'(seed_out), exp_ok ? exp_seed : 0);
   endtask

   task automatic run_case(input string name, input logic [11:0] d, input bit exp_ok,
                           input int exp_seed, input bit noise);
      bit ok;
      int ms, mc;
      model_search(d, ok, ms, mc);
      for (int k = 0; k < NOBS; k++) send_sample(seg_pat[d[3*k +: 3]]);
      wait_result(name, exp_ok, exp_seed, mc, noise);
   endtask

   initial begin
      bit          ok;
      int          ms, mc;
      logic [11:0] d;

      seg_pat[0] = 7'b0111111; seg_pat[1] = 7'b0000110;
      seg_pat[2] = 7'b1011011; seg_pat[3] = 7'b1001111;
      seg_pat[4] = 7'b1100110; seg_pat[5] = 7'b1101101;
      seg_pat[6] = 7'b1111100; seg_pat[7] = 7'b0000111;
      for (int s = 0; s < NSEED; s++)
         for (int k = 0; k < NOBS; k++) dig[s][k] = model_digit(s, k);

      vecs[0] = '{d: 12'h000, exp_found: 1'b1, exp_seed: 0};
      vecs[1] = '{d: pack_seed(1), exp_found: 1'b1, exp_seed: 1};
      vecs[2] = '{d: 12'hFFF, exp_found: 1'b0, exp_seed: 0};

      reset = 1'b1; seg_valid = 1'b0; seg_in = 7'd0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_busy", int'(busy), 0);
      check("rst_found", int'(found), 0);
      check("rst_fail", int'(fail), 0);
      check("rst_bad_seg", int'(bad_seg), 0);
      check("rst_seed", int'(seed_out), 0);

      // Undecodable pattern in IDLE
      send_sample(7'b1111111);
      check("idle_bad_pulse", int'(bad_seg), 1);
      check("idle_bad_busy", int'(busy), 0);
      @(negedge clk);
      check("idle_bad_end", int'(bad_seg), 0);

      for (int i = 0; i < 3; i++)
         run_case($sformatf("vec%0d", i), vecs[i].d, vecs[i].exp_found, vecs[i].exp_seed, 1'b0);

      for (int s = 0; s < NSEED; s++) begin
         d = pack_seed(s);
         model_search(d, ok, ms, mc);
         run_case($sformatf("seed%0d", s), d, ok, ms, 1'b0);
      end

      for (int i = 0; i < 16; i++) begin
         d = 12'($urandom);
         model_search(d, ok, ms, mc);
         run_case($sformatf("rand%0d", i), d, ok, ms, 1'b0);
      end

      // Bad pattern mid-collect must not consume a slot
      d = pack_seed(5);
      model_search(d, ok, ms, mc);
      send_sample(seg_pat[d[2:0]]);
      check("col_busy", int'(busy), 1);
      send_sample(7'b1111111);
      check("col_bad_pulse", int'(bad_seg), 1);
      check("col_bad_busy", int'(busy), 1);
      @(negedge clk);
      check("col_bad_end", int'(bad_seg), 0);
      send_sample(seg_pat[d[5:3]]);
      send_sample(seg_pat[d[8:6]]);
      repeat (300) @(negedge clk);
      check("col_hold_found", int'(found), 0);
      check("col_hold_fail", int'(fail), 0);
      check("col_hold_busy", int'(busy), 1);
      send_sample(seg_pat[d[11:9]]);
      wait_result("col_bad", ok, ms, mc, 1'b0);

      // Reset in the middle of a long search
      for (int k = 0; k < NOBS; k++) send_sample(seg_pat[7]);
      repeat (10) @(negedge clk);
      check("abort_pre_busy", int'(busy), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_found", int'(found), 0);
      check("abort_fail", int'(fail), 0);
      check("abort_seed", int'(seed_out), 0);

      // Strobes during SEARCH are ignored
      d = pack_seed(40);
      model_search(d, ok, ms, mc);
      run_case("noise", d, ok, ms, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
